// File: rtl/rob_commit_unit_if.sv
// Head-of-ROB, register-file write and store-memory signals of the commit stage.
interface rob_commit_unit_if #(
    parameter int unsigned ADDRESS_WIDTH = 10,
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned TAG_WIDTH     = 7,
    parameter int unsigned RF_WIDTH      = 5
);
    // ROB head entry
    logic                     head_valid;
    logic                     head_done;
    logic [TAG_WIDTH-1:0]     head_tag;
    logic [RF_WIDTH-1:0]      head_rd;
    logic [DATA_WIDTH-1:0]    head_data;
    logic                     head_isStore;
    logic [ADDRESS_WIDTH-1:0] head_address;
    logic                     rob_pop;

    // register-file writeback
    logic                     rf_we;
    logic [RF_WIDTH-1:0]      rf_rd;
    logic [DATA_WIDTH-1:0]    rf_data;
    logic [TAG_WIDTH-1:0]     rf_tag;

    // data-memory store handshake
    logic                     st_req;
    logic [ADDRESS_WIDTH-1:0] st_address;
    logic [DATA_WIDTH-1:0]    st_data;
    logic                     st_ack;

    // commit unit side
    modport master (
        input  head_valid, head_done, head_tag, head_rd, head_data,
               head_isStore, head_address, st_ack,
        output rob_pop, rf_we, rf_rd, rf_data, rf_tag,
               st_req, st_address, st_data
    );

    // ROB / register file / memory side
    modport slave (
        output head_valid, head_done, head_tag, head_rd, head_data,
               head_isStore, head_address, st_ack,
        input  rob_pop, rf_we, rf_rd, rf_data, rf_tag,
               st_req, st_address, st_data
    );
endinterface

// File: rtl/rob_commit_unit.sv
// In-order retirement of the ROB head: register writeback or store via req/ack.
module rob_commit_unit #(
    parameter int unsigned ADDRESS_WIDTH = 10,
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned TAG_WIDTH     = 7,
    parameter int unsigned RF_WIDTH      = 5,
    parameter int unsigned COUNT_WIDTH   = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   halt,
    input  logic                   flush,
    rob_commit_unit_if.master      bus,
    output logic [COUNT_WIDTH-1:0] retired_count,
    output logic                   busy
);

    typedef enum logic [0:0] {
        RUN        = 1'b0,
        STORE_WAIT = 1'b1
    } state_t;

    state_t state;
    state_t state_next;

    logic                     commit_ok;
    logic                     pop;

    logic                     rf_we_q,      rf_we_next;
    logic [RF_WIDTH-1:0]      rf_rd_q,      rf_rd_next;
    logic [DATA_WIDTH-1:0]    rf_data_q,    rf_data_next;
    logic [TAG_WIDTH-1:0]     rf_tag_q,     rf_tag_next;
    logic                     st_req_q,     st_req_next;
    logic [ADDRESS_WIDTH-1:0] st_address_q, st_address_next;
    logic [DATA_WIDTH-1:0]    st_data_q,    st_data_next;
    logic [COUNT_WIDTH-1:0]   count_q,      count_next;

    // head may retire only when ready and not held off
    assign commit_ok = bus.head_valid & bus.head_done & ~halt & ~flush;

    // state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    // next state: a ready store parks here until memory accepts it
    always_comb begin
        state_next = state;
        case (state)
            RUN: begin
                if (commit_ok && bus.head_isStore) begin
                    state_next = STORE_WAIT;
                end
            end
            STORE_WAIT: begin
                if (bus.st_ack) begin
                    state_next = RUN;
                end
            end
            default: state_next = RUN;
        endcase
    end

    // outputs: same-cycle pop plus next values of the registered outputs
    always_comb begin
        pop             = 1'b0;
        rf_we_next      = 1'b0;
        rf_rd_next      = rf_rd_q;
        rf_data_next    = rf_data_q;
        rf_tag_next     = rf_tag_q;
        st_req_next     = st_req_q;
        st_address_next = st_address_q;
        st_data_next    = st_data_q;
        count_next      = count_q;
        case (state)
            RUN: begin
                if (commit_ok && !bus.head_isStore) begin
                    pop          = 1'b1;
                    rf_we_next   = (bus.head_rd != RF_WIDTH'(0));
                    rf_rd_next   = bus.head_rd;
                    rf_data_next = bus.head_data;
                    rf_tag_next  = bus.head_tag;
                    count_next   = count_q + COUNT_WIDTH'(1);
                end else if (commit_ok && bus.head_isStore) begin
                    st_req_next     = 1'b1;
                    st_address_next = bus.head_address;
                    st_data_next    = bus.head_data;
                end
            end
            STORE_WAIT: begin
                // halt/flush ignored: the store is already committed
                if (bus.st_ack) begin
                    pop         = 1'b1;
                    st_req_next = 1'b0;
                    count_next  = count_q + COUNT_WIDTH'(1);
                end
            end
            default: begin
                st_req_next = 1'b0;
            end
        endcase
    end

    // registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            rf_we_q      <= 1'b0;
            rf_rd_q      <= '0;
            rf_data_q    <= '0;
            rf_tag_q     <= '0;
            st_req_q     <= 1'b0;
            st_address_q <= '0;
            st_data_q    <= '0;
            count_q      <= '0;
        end else begin
            rf_we_q      <= rf_we_next;
            rf_rd_q      <= rf_rd_next;
            rf_data_q    <= rf_data_next;
            rf_tag_q     <= rf_tag_next;
            st_req_q     <= st_req_next;
            st_address_q <= st_address_next;
            st_data_q    <= st_data_next;
            count_q      <= count_next;
        end
    end

    assign bus.rob_pop    = pop;
    assign bus.rf_we      = rf_we_q;
    assign bus.rf_rd      = rf_rd_q;
    assign bus.rf_data    = rf_data_q;
    assign bus.rf_tag     = rf_tag_q;
    assign bus.st_req     = st_req_q;
    assign bus.st_address = st_address_q;
    assign bus.st_data    = st_data_q;
    assign retired_count  = count_q;
    assign busy           = (state == STORE_WAIT);

endmodule
